// File: rtl/fsk_modulate_if.sv
// rtl/fsk_modulate_if.sv - frame load handshake and FSK output bundle for fsk_modulate
interface fsk_modulate_if;
    logic [13:0] Hamcode;
    logic        load_valid;
    logic        load_ready;
    logic        fsk_signal;
    logic        clk_bitTransferRate;
    logic        busy;
    logic        frame_done;

    modport master (
        output Hamcode,
        output load_valid,
        input  load_ready,
        input  fsk_signal,
        input  clk_bitTransferRate,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  Hamcode,
        input  load_valid,
        output load_ready,
        output fsk_signal,
        output clk_bitTransferRate,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/fsk_modulate.sv
// rtl/fsk_modulate.sv - serialises a 14-bit codeword as a binary FSK carrier, bit 0 first
module fsk_modulate #(
    parameter int BIT_CYCLES = 64,
    parameter int MARK_HALF  = 2,
    parameter int SPACE_HALF = 8
) (
    input  logic          clk,
    input  logic          reset,
    fsk_modulate_if.slave bus
);
    localparam int             CW     = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0]  C_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0]  C_HALF = CW'(BIT_CYCLES / 2);
    localparam logic [CW-1:0]  MARK_H  = CW'(MARK_HALF);
    localparam logic [CW-1:0]  SPACE_H = CW'(SPACE_HALF);
    localparam logic [3:0]     B_LAST = 4'd13;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t        r_state, w_state_nx;
    logic [3:0]    r_bit, w_bit_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [CW-1:0] r_ph, w_ph_nx;
    logic [13:0]   r_shadow, w_shadow_nx;
    logic          r_fsk, r_bitclk, r_busy, r_done;
    logic          w_fsk_nx;
    logic          w_last_cycle;
    logic          w_ready;
    logic          w_handshake;
    logic          w_cur_bit;
    logic [CW-1:0] w_half_nx;

    assign w_last_cycle = (r_state == S_SEND) && (r_bit == B_LAST) && (r_cnt == C_LAST);
    assign w_ready      = (r_state == S_IDLE) || w_last_cycle;
    assign w_handshake  = bus.load_valid && w_ready;

    always_comb begin
        w_state_nx  = r_state;
        w_bit_nx    = r_bit;
        w_cnt_nx    = r_cnt;
        w_shadow_nx = r_shadow;
        case (r_state)
            S_IDLE: begin
                if (w_handshake) begin
                    w_state_nx  = S_SEND;
                    w_bit_nx    = 4'd0;
                    w_cnt_nx    = '0;
                    w_shadow_nx = bus.Hamcode;
                end
            end
            S_SEND: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_nx = '0;
                    if (r_bit == B_LAST) begin
                        w_bit_nx = 4'd0;
                        if (w_handshake) begin
                            w_shadow_nx = bus.Hamcode;
                        end else begin
                            w_state_nx = S_IDLE;
                        end
                    end else begin
                        w_bit_nx = r_bit + 4'd1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Carrier phase is rebuilt from zero at the start of each bit; the half
    // period follows the bit that the next cycle will be transmitting.
    assign w_cur_bit = w_shadow_nx[w_bit_nx];
    assign w_half_nx = w_cur_bit ? MARK_H : SPACE_H;

    always_comb begin
        w_ph_nx  = '0;
        w_fsk_nx = 1'b0;
        if ((w_state_nx == S_SEND) && (w_cnt_nx != '0)) begin
            if (r_ph == (w_half_nx - 1'b1)) begin
                w_ph_nx  = '0;
                w_fsk_nx = ~r_fsk;
            end else begin
                w_ph_nx  = r_ph + 1'b1;
                w_fsk_nx = r_fsk;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_bit    <= 4'd0;
            r_cnt    <= '0;
            r_ph     <= '0;
            r_shadow <= 14'd0;
            r_fsk    <= 1'b0;
            r_bitclk <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_bit    <= w_bit_nx;
            r_cnt    <= w_cnt_nx;
            r_ph     <= w_ph_nx;
            r_shadow <= w_shadow_nx;
            r_fsk    <= w_fsk_nx;
            r_bitclk <= (w_state_nx == S_SEND) && (w_cnt_nx < C_HALF);
            r_busy   <= (w_state_nx == S_SEND);
            r_done   <= (w_state_nx == S_SEND) && (w_bit_nx == B_LAST) && (w_cnt_nx == C_LAST);
        end
    end

    assign bus.load_ready          = w_ready;
    assign bus.fsk_signal          = r_fsk;
    assign bus.clk_bitTransferRate = r_bitclk;
    assign bus.busy                = r_busy;
    assign bus.frame_done          = r_done;
endmodule

// File: tb/tb_fsk_modulate.sv
// tb/tb_fsk_modulate.sv - self-checking bench for fsk_modulate
module tb_fsk_modulate;
    localparam int BC    = 64;
    localparam int MARK  = 2;
    localparam int SPACE = 8;
    localparam int FRAME = 14 * BC;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;
    int   dut_hs = 0;

    fsk_modulate_if ifc ();

    fsk_modulate #(.BIT_CYCLES(BC), .MARK_HALF(MARK), .SPACE_HALF(SPACE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: one frame is a flat run of 14*BC cycles indexed by k.
    bit          m_active = 1'b0;
    int          m_k = 0;
    logic [13:0] m_word = 14'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_word   <= 14'd0;
        end else if (ifc.load_valid && (!m_active || m_k == FRAME - 1)) begin
            m_active <= 1'b1;
            m_k      <= 0;
            m_word   <= ifc.Hamcode;
        end else if (m_active) begin
            if (m_k == FRAME - 1) m_active <= 1'b0;
            else                  m_k <= m_k + 1;
        end
    end

    function automatic logic [4:0] model_out(input bit act, input int k, input logic [13:0] w);
        int b, c, half;
        logic f, bc_hi, dn;
        if (!act) return 5'b00001;
        b     = k / BC;
        c     = k % BC;
        half  = w[b] ? MARK : SPACE;
        f     = ((c / half) % 2) == 1;
        bc_hi = c < BC / 2;
        dn    = (k == FRAME - 1);
        return {f, bc_hi, 1'b1, dn, dn};
    endfunction

    always @(negedge clk) begin
        if (chk_en)
            chk("cycle_outputs",
                {27'd0, ifc.fsk_signal, ifc.clk_bitTransferRate, ifc.busy, ifc.frame_done, ifc.load_ready},
                {27'd0, model_out(m_active, m_k, m_word)});
    end

    always @(posedge clk) begin
        if (!reset && ifc.load_valid && ifc.load_ready) dut_hs <= dut_hs + 1;
    end

    typedef struct {
        logic [13:0] ham;
        logic [13:0] exp_word;
        int          exp_done;
    } vec_t;

    task automatic check_idle(input string nm);
        @(negedge clk);
        chk(nm, {27'd0, ifc.fsk_signal, ifc.clk_bitTransferRate, ifc.busy, ifc.frame_done, ifc.load_ready},
            32'h1);
    endtask

    // Single frame; demodulates by counting rising edges in the high half of each bit.
    task automatic send_frame(input logic [13:0] w, input logic [13:0] exp_w, input int exp_done);
        logic [13:0] demod;
        int done_at, hi, edges;
        logic pf;
        @(posedge clk); #2;
        ifc.load_valid = 1'b1;
        ifc.Hamcode    = w;
        @(posedge clk); #2;
        ifc.load_valid = 1'b0;
        ifc.Hamcode    = ~w;
        done_at = -1;
        hi      = 0;
        demod   = 14'd0;
        for (int b = 0; b < 14; b++) begin
            edges = 0;
            pf    = 1'b0;
            for (int c = 0; c < BC; c++) begin
                @(negedge clk);
                if (ifc.fsk_signal && !pf && ifc.clk_bitTransferRate) edges++;
                pf = ifc.fsk_signal;
                if (ifc.clk_bitTransferRate) hi++;
                if (ifc.frame_done && done_at < 0) done_at = b * BC + c + 1;
            end
            demod[b] = (edges >= 4);
            chk("edges_in_high_half", edges, exp_w[b] ? 8 : 2);
        end
        chk("demod_word", {18'd0, demod}, {18'd0, exp_w});
        chk("frame_done_cycle", done_at, exp_done);
        chk("bitclk_high_cycles", hi, 14 * BC / 2);
        check_idle("idle_after_frame");
    endtask

    vec_t vecs[4];
    int   n;
    int   hs_base;
    logic [13:0] rw;

    initial begin
        reset          = 1'b1;
        ifc.load_valid = 1'b0;
        ifc.Hamcode    = 14'd0;
        #1;
        chk("reset_state", {27'd0, ifc.fsk_signal, ifc.clk_bitTransferRate, ifc.busy, ifc.frame_done, ifc.load_ready},
            32'h1);
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        rw = 14'($urandom);
        vecs[0] = '{14'h3FFF, 14'h3FFF, FRAME};
        vecs[1] = '{14'h0000, 14'h0000, FRAME};
        vecs[2] = '{14'h2A55, 14'h2A55, FRAME};
        vecs[3] = '{rw, rw, FRAME};
        for (int i = 0; i < 4; i++) send_frame(vecs[i].ham, vecs[i].exp_word, vecs[i].exp_done);

        // Back-to-back frames with load_valid held high across the boundary.
        hs_base = dut_hs;
        @(posedge clk); #2;
        ifc.load_valid = 1'b1;
        ifc.Hamcode    = 14'h1234;
        @(posedge clk); #2;
        ifc.Hamcode = 14'h0ABC;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ifc.frame_done && n < 2000);
        chk("b2b_first_done_cycle", n, FRAME);
        chk("b2b_ready_at_done", {31'd0, ifc.load_ready}, 32'd1);
        @(posedge clk); #2;
        ifc.load_valid = 1'b0;
        @(negedge clk);
        chk("b2b_no_gap", {29'd0, ifc.busy, ifc.clk_bitTransferRate, ifc.fsk_signal}, 32'b110);
        n = 1;
        while (!ifc.frame_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_second_done_cycle", n, FRAME);
        check_idle("b2b_idle");
        chk("b2b_handshakes", dut_hs - hs_base, 2);

        // Reset in the middle of bit 7, with a handshake attempt during reset.
        @(posedge clk); #2;
        ifc.load_valid = 1'b1;
        ifc.Hamcode    = 14'h1555;
        @(posedge clk); #2;
        ifc.load_valid = 1'b0;
        repeat (7 * BC + 20) @(posedge clk);
        #2 reset = 1'b1;
        ifc.load_valid = 1'b1;
        #1;
        chk("reset_midframe_outputs",
            {27'd0, ifc.fsk_signal, ifc.clk_bitTransferRate, ifc.busy, ifc.frame_done, ifc.load_ready}, 32'h1);
        hs_base = dut_hs;
        repeat (3) @(posedge clk);
        #2;
        reset          = 1'b0;
        ifc.load_valid = 1'b0;
        chk("reset_handshake_ignored", dut_hs - hs_base, 0);
        repeat (4) check_idle("idle_after_reset");
        send_frame(14'h2C3A, 14'h2C3A, FRAME);

        // Random load_valid with Hamcode churning every cycle.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #2;
            ifc.Hamcode    = 14'($urandom);
            ifc.load_valid = ($urandom_range(0, 99) < 3);
        end
        ifc.load_valid = 1'b0;
        repeat (FRAME + 4) @(posedge clk);
        check_idle("idle_final");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
